// File: rtl/lap_stopwatch.sv
// ============================================================================
// Module   : lap_stopwatch
// Purpose  : BCD stopwatch with run/pause/clear control, prescaled tick,
//            lap capture with one-cycle strobe, and sticky wrap flag.
// Revision : 1.0
// ============================================================================
`default_nettype none

module lap_stopwatch #(
   parameter int DIGITS   = 4,
   parameter int TICK_DIV = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                pause,
   input  logic                clear,
   input  logic                lap,
   output logic [4*DIGITS-1:0] count,
   output logic [4*DIGITS-1:0] lap_count,
   output logic                lap_strobe,
   output logic                running,
   output logic                overflow
);

   localparam int         W        = 4 * DIGITS;
   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_RUN    = 2'd1;
   localparam logic [1:0] S_PAUSED = 2'd2;
   localparam logic [15:0] PRE_LAST = 16'(TICK_DIV - 1);

   logic [1:0]   state;
   logic [1:0]   state_next;
   logic [15:0]  prescaler;
   logic         advance;
   logic         tick;
   logic         wrap;
   logic         carry;
   logic         lap_take;
   logic [W-1:0] count_inc;

   // A pause or clear sampled on this edge suppresses counting on the same edge.
   assign advance  = (state == S_RUN) && !pause && !clear;
   assign tick     = (prescaler == PRE_LAST);
   assign lap_take = lap && !clear && ((state == S_RUN) || (state == S_PAUSED));

   always_comb begin
      count_inc = count;
      carry     = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (carry) begin
            if (count[4*i +: 4] == 4'd9) begin
               count_inc[4*i +: 4] = 4'd0;
            end else begin
               count_inc[4*i +: 4] = count[4*i +: 4] + 4'd1;
               carry               = 1'b0;
            end
         end
      end
      wrap = carry;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      if (clear) begin
         state_next = S_IDLE;
      end else begin
         case (state)
            S_IDLE:   if (start && !pause) state_next = S_RUN;
            S_RUN:    if (pause)           state_next = S_PAUSED;
            S_PAUSED: if (start && !pause) state_next = S_RUN;
            default:                       state_next = S_IDLE;
         endcase
      end
   end

   always_comb begin
      running = (state == S_RUN);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         prescaler <= '0;
         count     <= '0;
         overflow  <= 1'b0;
      end else if (clear) begin
         prescaler <= '0;
         count     <= '0;
         overflow  <= 1'b0;
      end else if (advance) begin
         if (tick) begin
            prescaler <= '0;
            count     <= count_inc;
            if (wrap) overflow <= 1'b1;
         end else begin
            prescaler <= prescaler + 16'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lap_count  <= '0;
         lap_strobe <= 1'b0;
      end else begin
         lap_strobe <= lap_take;
         if (clear) begin
            lap_count <= '0;
         end else if (lap_take) begin
            lap_count <= count;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_lap_stopwatch.sv
// ============================================================================
// Module   : tb_lap_stopwatch
// Purpose  : Directed vector bench for lap_stopwatch in three configurations.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_lap_stopwatch;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0, pause = 1'b0, clear = 1'b0, lap = 1'b0;

   logic [15:0] c4, lc4;  logic s4, r4, o4;
   logic [7:0]  c2, lc2;  logic s2, r2, o2;
   logic [15:0] c5, lc5;  logic s5, r5, o5;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   lap_stopwatch #(.DIGITS(4), .TICK_DIV(1)) u4 (
      .clk(clk), .rst(rst_n), .start(start), .pause(pause), .clear(clear), .lap(lap),
      .count(c4), .lap_count(lc4), .lap_strobe(s4), .running(r4), .overflow(o4));

   lap_stopwatch #(.DIGITS(2), .TICK_DIV(1)) u2 (
      .clk(clk), .rst(rst_n), .start(start), .pause(pause), .clear(clear), .lap(lap),
      .count(c2), .lap_count(lc2), .lap_strobe(s2), .running(r2), .overflow(o2));

   lap_stopwatch #(.DIGITS(4), .TICK_DIV(5)) u5 (
      .clk(clk), .rst(rst_n), .start(start), .pause(pause), .clear(clear), .lap(lap),
      .count(c5), .lap_count(lc5), .lap_strobe(s5), .running(r5), .overflow(o5));

   typedef struct {
      logic        start;
      logic        pause;
      logic        clear;
      logic        lap;
      logic [15:0] cnt;
      logic        run;
      logic [15:0] lcnt;
      logic        strb;
      logic        ovf;
   } vec_t;

   vec_t vecs[16];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      //                start pause clear lap  count      run  lap_count  strb ovf
      vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
      vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
      vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b0, 1'b0};
      vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0001, 1'b1, 16'h0000, 1'b0, 1'b0};
      vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0002, 1'b1, 16'h0001, 1'b1, 1'b0};
      vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0003, 1'b1, 16'h0002, 1'b1, 1'b0};
      vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0004, 1'b1, 16'h0002, 1'b0, 1'b0};
      vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0004, 1'b0, 16'h0002, 1'b0, 1'b0};
      vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0004, 1'b0, 16'h0002, 1'b0, 1'b0};
      vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0004, 1'b0, 16'h0004, 1'b1, 1'b0};
      vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0004, 1'b1, 16'h0004, 1'b0, 1'b0};
      vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0005, 1'b1, 16'h0004, 1'b0, 1'b0};
      vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0006, 1'b1, 16'h0004, 1'b0, 1'b0};
      vecs[13] = '{1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
      vecs[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b0, 1'b0};
      vecs[15] = '{1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};

      // Reset state
      run(2);
      chk("rst_count", 32'(c4), 32'h0);
      chk("rst_running", 32'(r4), 32'h0);
      chk("rst_lap_count", 32'(lc4), 32'h0);
      chk("rst_overflow", 32'(o4), 32'h0);
      rst_n = 1'b1;

      // Table: basic control, lap capture, priorities
      for (int i = 0; i < 16; i++) begin
         start = vecs[i].start; pause = vecs[i].pause;
         clear = vecs[i].clear; lap   = vecs[i].lap;
         run(1);
         chk($sformatf("v%0d_count", i),     32'(c4),  32'(vecs[i].cnt));
         chk($sformatf("v%0d_running", i),   32'(r4),  32'(vecs[i].run));
         chk($sformatf("v%0d_lap_count", i), 32'(lc4), 32'(vecs[i].lcnt));
         chk($sformatf("v%0d_strobe", i),    32'(s4),  32'(vecs[i].strb));
         chk($sformatf("v%0d_overflow", i),  32'(o4),  32'(vecs[i].ovf));
      end
      start = 1'b0; pause = 1'b0; clear = 1'b0; lap = 1'b0;

      // Run 12 edges, then up to 39 and lap+pause together
      start = 1'b1; run(1); start = 1'b0;
      run(12);
      chk("run12_count", 32'(c4), 32'h0012);
      chk("run12_running", 32'(r4), 32'h1);
      run(27);
      chk("run39_count", 32'(c4), 32'h0039);
      lap = 1'b1; pause = 1'b1; run(1); lap = 1'b0; pause = 1'b0;
      chk("lp_lap_count", 32'(lc4), 32'h0039);
      chk("lp_strobe", 32'(s4), 32'h1);
      chk("lp_count", 32'(c4), 32'h0039);
      chk("lp_running", 32'(r4), 32'h0);
      run(1);
      chk("lp_strobe_end", 32'(s4), 32'h0);
      chk("lp_count_hold", 32'(c4), 32'h0039);

      // Two-digit wrap and sticky overflow
      clear = 1'b1; run(1); clear = 1'b0;
      start = 1'b1; run(1); start = 1'b0;
      run(99);
      chk("w99_count", 32'(c2), 32'h99);
      chk("w99_overflow", 32'(o2), 32'h0);
      run(1);
      chk("w100_count", 32'(c2), 32'h00);
      chk("w100_overflow", 32'(o2), 32'h1);
      chk("w100_count4", 32'(c4), 32'h0100);
      chk("w100_overflow4", 32'(o4), 32'h0);
      run(1);
      chk("w101_count", 32'(c2), 32'h01);
      chk("w101_sticky", 32'(o2), 32'h1);
      clear = 1'b1; run(1); clear = 1'b0;
      chk("wclr_count", 32'(c2), 32'h00);
      chk("wclr_overflow", 32'(o2), 32'h0);
      chk("wclr_running", 32'(r2), 32'h0);

      // Prescaler TICK_DIV=5 with pause/resume
      start = 1'b1; run(1); start = 1'b0;
      run(4);
      chk("p4_count", 32'(c5), 32'h0000);
      run(1);
      chk("p5_count", 32'(c5), 32'h0001);
      run(18);
      chk("p23_count", 32'(c5), 32'h0004);
      pause = 1'b1; run(10); pause = 1'b0;
      chk("pp_count", 32'(c5), 32'h0004);
      chk("pp_running", 32'(r5), 32'h0);
      start = 1'b1; run(1); start = 1'b0;
      chk("pr0_count", 32'(c5), 32'h0004);
      chk("pr0_running", 32'(r5), 32'h1);
      run(1);
      chk("pr1_count", 32'(c5), 32'h0004);
      run(1);
      chk("pr2_count", 32'(c5), 32'h0005);

      // Asynchronous reset mid-count
      clear = 1'b1; run(1); clear = 1'b0;
      start = 1'b1; run(1); start = 1'b0;
      run(346);
      lap = 1'b1; run(1); lap = 1'b0;
      chk("ar_count", 32'(c4), 32'h0347);
      chk("ar_lap_count", 32'(lc4), 32'h0346);
      chk("ar_strobe", 32'(s4), 32'h1);
      chk("ar_ovf2", 32'(o2), 32'h1);
      #2 rst_n = 1'b0;
      #1;
      chk("ar_async_count", 32'(c4), 32'h0);
      chk("ar_async_lap_count", 32'(lc4), 32'h0);
      chk("ar_async_strobe", 32'(s4), 32'h0);
      chk("ar_async_running", 32'(r4), 32'h0);
      chk("ar_async_ovf2", 32'(o2), 32'h0);
      run(1);
      rst_n = 1'b1;
      run(2);
      chk("ar_idle_running", 32'(r4), 32'h0);
      chk("ar_idle_count", 32'(c4), 32'h0);
      start = 1'b1; run(1); start = 1'b0;
      chk("ar_restart_running", 32'(r4), 32'h1);
      chk("ar_restart_count0", 32'(c4), 32'h0000);
      run(1);
      chk("ar_restart_count1", 32'(c4), 32'h0001);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/lap_stopwatch.md
LAP_STOPWATCH -- requirements
Module: lap_stopwatch

Interface
REQ-001 Parameter DIGITS, default 4, number of BCD digits in the count (legal 1..8).
REQ-002 Parameter TICK_DIV, default 1, clk cycles per count increment while running (legal 1..2^16).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous active-low reset.
REQ-005 start  input  1  level-sampled request to run.
REQ-006 pause  input  1  level-sampled request to halt counting.
REQ-007 clear  input  1  synchronous clear to idle/zero.
REQ-008 lap  input  1  capture request for current count.
REQ-009 count  output  4*DIGITS  live BCD count; digit 0 in bits [3:0] (ones), digit i in bits [4i+3:4i].
REQ-010 lap_count  output  4*DIGITS  last captured BCD count.
REQ-011 lap_strobe  output  1  one-cycle pulse when lap_count updates.
REQ-012 running  output  1  high while FSM is in RUN.
REQ-013 overflow  output  1  sticky flag: count wrapped past all-9s.

Function
REQ-014 FSM states IDLE, RUN, PAUSED; state, count, prescaler, lap_count, lap_strobe and overflow are registered.
REQ-015 Transition priority per edge: clear > pause > start.
REQ-016 clear=1 in any state -> next state IDLE, count=0, prescaler=0, overflow=0, lap_count=0, lap_strobe=0.
REQ-017 IDLE: start=1 (pause=0) -> RUN; otherwise stay IDLE.
REQ-018 RUN: pause=1 -> PAUSED; start alone has no effect.
REQ-019 PAUSED: start=1 (pause=0) -> RUN, resuming without resetting count or prescaler.
REQ-020 running = (state == RUN), registered, no combinational path from inputs.
REQ-021 Prescaler counts 0..TICK_DIV-1 only on edges where state is RUN; tick asserted when prescaler == TICK_DIV-1, prescaler then returns to 0; prescaler holds in PAUSED and IDLE.
REQ-022 TICK_DIV=1: tick asserted on every edge in RUN.
REQ-023 On an edge with state RUN and tick, count increments by one in BCD: digit 9 -> 0 with carry into next digit; digit values never exceed 9.
REQ-024 Wrap: count all 9s plus tick -> count all 0s, overflow set to 1 on the same edge; counting continues.
REQ-025 overflow stays 1 until clear or reset.
REQ-026 Latency: start sampled at edge k -> running=1 after edge k; first increment at edge k+TICK_DIV.
REQ-027 pause sampled at edge k -> no increment at edge k or later until resumed; count value visible after edge k is final.
REQ-028 lap=1 at an edge with state RUN or PAUSED (and clear=0) -> lap_count takes the count value present before that edge; lap_strobe=1 for exactly the following cycle.
REQ-029 lap in IDLE is ignored: lap_count unchanged, lap_strobe=0.
REQ-030 lap held high for N edges -> N captures and N consecutive strobe cycles.
REQ-031 lap and pause on the same edge: capture occurs (pre-edge value) and state goes PAUSED.
REQ-032 lap and clear on the same edge: clear wins, no capture, lap_strobe=0.

Reset
REQ-033 rst=0 asynchronously forces state IDLE, count=0, lap_count=0, prescaler=0, lap_strobe=0, overflow=0, running=0, independent of clk.
REQ-034 rst asserted mid-count aborts counting immediately; after release the block waits in IDLE for start.
REQ-035 Release of rst is synchronous to clk externally; first functional edge is the first rising edge with rst=1.

Verification
REQ-036 DIGITS=4, TICK_DIV=1: start 1 cycle, run 12 edges -> count=16'h0012, running=1.
REQ-037 DIGITS=2, TICK_DIV=1: run from 0 for 100 edges -> count 8'h00, overflow=1; clear 1 cycle -> count 8'h00, overflow=0, state IDLE.
REQ-038 DIGITS=4, TICK_DIV=5: run 23 edges -> count=16'h0004; pause 10 edges -> count=16'h0004; resume 2 edges -> count=16'h0005 (prescaler resumed from 3).
REQ-039 DIGITS=4, TICK_DIV=1: at count=16'h0039 assert lap and pause same edge -> lap_count=16'h0039, lap_strobe pulse 1 cycle, count held 16'h0039, state PAUSED.
REQ-040 start, pause and clear together in RUN -> IDLE, count 0; start with pause in IDLE -> stays IDLE; lap in IDLE -> no strobe.
REQ-041 rst=0 asserted between clock edges at count=16'h0347 -> all outputs 0 before the next edge; start after release -> count restarts from 16'h0000.
